mem_dump: RTL and testbench

MEM_DUMP -- requirements
Module: mem_dump

---
 rtl/mem_dump_pkg.sv | 19 +
 rtl/dump_fifo.sv | 76 +++++++
 rtl/mem_dump.sv | 172 +++++++++++++++++
 tb/tb_mem_dump.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dump_pkg.sv
// Shared defaults, FSM encoding and small helpers for the memory dump engine.
package mem_dump_pkg;

    localparam int unsigned DEFAULT_ADRS_W     = 11;
    localparam int unsigned DEFAULT_DATA_W     = 32;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Pointer width for a buffer of the given depth (at least one bit).
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dump_fifo.sv
// Small synchronous buffer holding {address, data} words with a flush input.
module dump_fifo
    import mem_dump_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_ADRS_W + DEFAULT_DATA_W,
    parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned IDX_W = idx_width(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_ptr;
    logic [IDX_W-1:0] wr_ptr_next;
    logic [IDX_W-1:0] rd_ptr_next;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_next;
    logic             valid_q;
    logic             do_pop;

    // Pointer advance with wrap at DEPTH and next occupancy.
    always_comb begin
        do_pop      = pop && valid_q;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        if (push) begin
            wr_ptr_next = (wr_ptr == IDX_W'(DEPTH - 1)) ? '0 : wr_ptr + IDX_W'(1);
        end
        if (do_pop) begin
            rd_ptr_next = (rd_ptr == IDX_W'(DEPTH - 1)) ? '0 : rd_ptr + IDX_W'(1);
        end
        occ_next = occ_q + OCC_W'(push) - OCC_W'(do_pop);
    end

    // Storage, pointers and a registered not-empty flag; flush empties the buffer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ_q   <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
            end
            wr_ptr  <= wr_ptr_next;
            rd_ptr  <= rd_ptr_next;
            occ_q   <= occ_next;
            valid_q <= (occ_next != '0);
        end
    end

    assign rdata     = mem[rd_ptr];
    assign valid     = valid_q;
    assign occupancy = occ_q;

endmodule

// File: rtl/mem_dump.sv
// Streams a contiguous range of memory words out through a ready/valid port.
module mem_dump
    import mem_dump_pkg::*;
#(
    parameter int unsigned ADRS_W     = DEFAULT_ADRS_W,
    parameter int unsigned DATA_W     = DEFAULT_DATA_W,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_en,
    input  logic              start,
    input  logic [ADRS_W-1:0] start_adrs,
    input  logic [ADRS_W:0]   count,
    output logic              r_enable,
    output logic [ADRS_W-1:0] r_adrs,
    input  logic [DATA_W-1:0] r_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADRS_W-1:0] out_adrs,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W  = ADRS_W + 1;
    localparam int unsigned WORD_W = ADRS_W + DATA_W;
    localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LOAD_W = OCC_W + 1;

    state_t            state;
    state_t            state_next;
    logic [ADRS_W-1:0] adrs_q;
    logic [CNT_W-1:0]  remaining_q;
    logic              inflight_q;
    logic [ADRS_W-1:0] inflight_adrs_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              accept;
    logic              issue;
    logic              flush;
    logic              done_next;
    logic              err_next;
    logic              pop;
    logic              push;
    logic              room;
    logic              last_out;
    logic [OCC_W-1:0]  occ;
    logic [LOAD_W-1:0] load;
    logic [WORD_W-1:0] fifo_rdata;

    // Buffer credit: a word leaving this cycle frees its slot for the read issued now.
    assign pop      = out_valid && out_ready;
    assign load     = LOAD_W'(occ) + LOAD_W'(inflight_q) - LOAD_W'(pop);
    assign room     = load < LOAD_W'(FIFO_DEPTH);
    assign last_out = !inflight_q && ((occ == '0) || ((occ == OCC_W'(1)) && pop));
    assign push     = inflight_q && !flush;

    // Next-state, read issue and completion decode.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        flush      = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (cpu_en) begin
                        done_next = 1'b1;
                        err_next  = 1'b1;
                    end else if (count == '0) begin
                        done_next = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (cpu_en) begin
                    flush      = 1'b1;
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else if (room) begin
                    issue = 1'b1;
                    if (remaining_q == CNT_W'(1)) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (cpu_en) begin
                    flush      = 1'b1;
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end else if (last_out) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read address/count tracking, in-flight tag and status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            adrs_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_adrs_q <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            if (accept) begin
                adrs_q      <= start_adrs;
                remaining_q <= count;
            end else if (issue) begin
                adrs_q      <= adrs_q + ADRS_W'(1);
                remaining_q <= remaining_q - CNT_W'(1);
            end
            inflight_q      <= issue;
            inflight_adrs_q <= adrs_q;
            busy_q          <= (state_next != ST_IDLE);
            done_q          <= done_next;
            err_q           <= err_next;
        end
    end

    dump_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .push      (push),
        .wdata     ({inflight_adrs_q, r_data}),
        .pop       (pop),
        .rdata     (fifo_rdata),
        .valid     (out_valid),
        .occupancy (occ)
    );

    assign r_enable = issue;
    assign r_adrs   = adrs_q;
    assign out_adrs = fifo_rdata[WORD_W-1:DATA_W];
    assign out_data = fifo_rdata[DATA_W-1:0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_dump.sv
// Bench for mem_dump: table of dump scenarios plus random dumps and reset sequences.
module tb_mem_dump;

    localparam int unsigned ADRS_W     = 11;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int          MEM_WORDS  = 2048;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              cpu_en = 1'b0;
    logic              start = 1'b0;
    logic [ADRS_W-1:0] start_adrs = '0;
    logic [ADRS_W:0]   count = '0;
    logic              r_enable;
    logic [ADRS_W-1:0] r_adrs;
    logic [DATA_W-1:0] r_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [ADRS_W-1:0] out_adrs;
    logic              busy;
    logic              done;
    logic              err;

    mem_dump #(
        .ADRS_W     (ADRS_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cpu_en     (cpu_en),
        .start      (start),
        .start_adrs (start_adrs),
        .count      (count),
        .r_enable   (r_enable),
        .r_adrs     (r_adrs),
        .r_data     (r_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_adrs   (out_adrs),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Memory model: data one cycle after the strobe, garbage otherwise.
    logic [DATA_W-1:0] mem [MEM_WORDS];
    always @(posedge clk) begin
        r_data <= r_enable ? mem[r_adrs] : DATA_W'($urandom);
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    typedef struct {
        int adrs;
        int cnt;
        bit cpu;
        int mode;          // 0 ready always, 1 toggling, 2 random
        int abort_after;   // raise cpu_en after this many transfers, -1 never
        int restart_cyc;   // extra start pulse while busy, -1 never
        bit exp_err;
        int exp_words;     // -1 when an abort makes the count timing-dependent
    } vec_t;

    function automatic vec_t mk(input int a, input int c, input bit cpu, input int mode,
                                input int ab, input int rs);
        vec_t v;
        v.adrs        = a;
        v.cnt         = c;
        v.cpu         = cpu;
        v.mode        = mode;
        v.abort_after = ab;
        v.restart_cyc = rs;
        v.exp_err     = cpu || (ab >= 0 && c != 0);
        v.exp_words   = cpu ? 0 : ((ab >= 0 && c != 0) ? -1 : c);
        return v;
    endfunction

    function automatic logic ready_val(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 2) == 0;
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    task automatic run_dump(input int idx, input vec_t v);
        logic [ADRS_W-1:0] got_a [$];
        logic [DATA_W-1:0] got_d [$];
        logic [ADRS_W-1:0] held_a;
        logic [DATA_W-1:0] held_d;
        logic [ADRS_W-1:0] ea;
        int    budget, reads, done_cyc, first_valid, abort_cyc;
        bit    aborted, prev_stall, done_busy, done_valid, done_err, exp_accept;
        int    bad_ren, bad_adrs, bad_stable, bad_occ, bad_busy;
        string tag;
        tag = $sformatf("v%0d_", idx);
        budget = 4 * v.cnt + 40;
        reads = 0; done_cyc = -1; first_valid = -1; abort_cyc = -10;
        aborted = 0; prev_stall = 0; done_busy = 0; done_valid = 0; done_err = 0;
        bad_ren = 0; bad_adrs = 0; bad_stable = 0; bad_occ = 0; bad_busy = 0;
        held_a = '0; held_d = '0;
        exp_accept = (v.cnt != 0) && !v.cpu;

        @(negedge clk);
        start      = 1'b1;
        start_adrs = ADRS_W'(v.adrs);
        count      = (ADRS_W + 1)'(v.cnt);
        cpu_en     = v.cpu;
        out_ready  = ready_val(v.mode, -1);

        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            start = (cyc == v.restart_cyc);
            if (start) begin
                start_adrs = ADRS_W'($urandom);
                count      = (ADRS_W + 1)'(5);
            end
            out_ready = ready_val(v.mode, cyc);
            if (exp_accept && v.abort_after >= 0 && !aborted && got_a.size() >= v.abort_after) begin
                cpu_en    = 1'b1;
                aborted   = 1;
                abort_cyc = cyc;
            end
            #1;
            if (r_enable) begin
                if (cpu_en) bad_ren++;
                if (r_adrs !== ADRS_W'(v.adrs + reads)) bad_adrs++;
                reads++;
            end
            if (prev_stall && abort_cyc != cyc - 1) begin
                if (out_valid !== 1'b1 || out_data !== held_d || out_adrs !== held_a) bad_stable++;
            end
            prev_stall = out_valid && !out_ready;
            held_a = out_adrs;
            held_d = out_data;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready) begin
                got_a.push_back(out_adrs);
                got_d.push_back(out_data);
            end
            if (reads - got_a.size() > int'(FIFO_DEPTH)) bad_occ++;
            if (done === 1'b1) begin
                done_cyc   = cyc;
                done_err   = err;
                done_busy  = busy;
                done_valid = out_valid;
                break;
            end
            if (busy !== exp_accept) bad_busy++;
        end

        @(negedge clk);
        start = 1'b0; cpu_en = 1'b0; out_ready = 1'b0;
        #1;
        check({tag, "done_pulse_one_cycle"}, 64'(done), 64'(0));

        check({tag, "done_seen"}, 64'(done_cyc >= 0), 64'(1));
        check({tag, "err"}, 64'(done_err), 64'(v.exp_err));
        check({tag, "busy_at_done"}, 64'(done_busy), 64'(0));
        if (v.exp_words >= 0) check({tag, "word_count"}, 64'(got_a.size()), 64'(v.exp_words));
        else                  check({tag, "word_count_bound"}, 64'(got_a.size() <= v.cnt), 64'(1));
        for (int i = 0; i < got_a.size(); i++) begin
            ea = ADRS_W'(v.adrs + i);
            check($sformatf("%sword%0d_adrs", tag, i), 64'(got_a[i]), 64'(ea));
            check($sformatf("%sword%0d_data", tag, i), 64'(got_d[i]), 64'(mem[ea]));
        end
        check({tag, "r_enable_with_cpu_en"}, 64'(bad_ren), 64'(0));
        check({tag, "r_adrs_sequence"}, 64'(bad_adrs), 64'(0));
        check({tag, "stall_stability"}, 64'(bad_stable), 64'(0));
        check({tag, "buffer_bound"}, 64'(bad_occ), 64'(0));
        check({tag, "busy_level"}, 64'(bad_busy), 64'(0));
        if (!exp_accept) begin
            check({tag, "done_latency"}, 64'(done_cyc), 64'(0));
            check({tag, "reads"}, 64'(reads), 64'(0));
        end else if (aborted) begin
            check({tag, "abort_done_latency"}, 64'(done_cyc), 64'(abort_cyc + 1));
            check({tag, "abort_valid_low"}, 64'(done_valid), 64'(0));
        end else begin
            check({tag, "reads"}, 64'(reads), 64'(v.cnt));
            if (v.mode == 0) begin
                check({tag, "first_valid_cycle"}, 64'(first_valid), 64'(2));
                check({tag, "done_cycle"}, 64'(done_cyc), 64'(v.cnt + 2));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "r_enable"}, 64'(r_enable), 64'(0));
        check({tag, "r_adrs"}, 64'(r_adrs), 64'(0));
        check({tag, "out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "out_data"}, 64'(out_data), 64'(0));
        check({tag, "out_adrs"}, 64'(out_adrs), 64'(0));
        check({tag, "busy"}, 64'(busy), 64'(0));
        check({tag, "done"}, 64'(done), 64'(0));
        check({tag, "err"}, 64'(err), 64'(0));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [$];
        int   nd;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = DATA_W'($urandom);
        mem[100] = DATA_W'(10);
        mem[101] = DATA_W'(11);

        vecs.push_back(mk(100,  2,    0, 0, -1, -1));
        vecs.push_back(mk(2046, 4,    0, 0, -1, -1));
        vecs.push_back(mk(300,  8,    0, 1, -1, -1));
        vecs.push_back(mk(7,    0,    0, 0, -1, -1));
        vecs.push_back(mk(50,   3,    1, 0, -1, -1));
        vecs.push_back(mk(900,  16,   0, 0,  5, -1));
        vecs.push_back(mk(1500, 10,   0, 0, -1,  3));
        vecs.push_back(mk(0,    1,    0, 0, -1, -1));
        vecs.push_back(mk(2040, 20,   0, 2, -1, -1));
        vecs.push_back(mk(1234, 2048, 0, 0, -1, -1));
        vecs.push_back(mk(77,   12,   0, 1,  3, -1));
        for (int i = 0; i < 24; i++) begin
            int c;
            c = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
            vecs.push_back(mk(int'($urandom_range(0, MEM_WORDS - 1)), c,
                              $urandom_range(0, 9) == 0, int'($urandom_range(0, 2)),
                              (c != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, c - 1)) : -1,
                              -1));
        end

        // Outputs under reset, then release just after an edge.
        #1;
        check_reset_outputs("por_");
        @(posedge clk);
        #1 resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_dump(i, vecs[i]);

        // Asynchronous reset in the middle of a dump.
        @(negedge clk);
        start = 1'b1; start_adrs = ADRS_W'(500); count = (ADRS_W + 1)'(16); out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("mid_reset_busy_before", 64'(busy), 64'(1));
        check("mid_reset_valid_before", 64'(out_valid), 64'(1));
        #1 resetn = 1'b0;
        #1;
        check_reset_outputs("mid_reset_");
        nd = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || r_enable !== 1'b0) nd++;
        end
        check("mid_reset_no_done", 64'(nd), 64'(0));
        resetn = 1'b1;
        run_dump(100, mk(600, 6, 0, 0, -1, -1));
        run_dump(101, mk(2047, 5, 0, 1, -1, -1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
